// File: rtl/uart_rx_os_if.sv
// UART receive front-end signal bundle.
// Serial line in, received byte and frame status out.
interface uart_rx_os_if;
    logic       rs232_rx;
    logic [7:0] rx_data;
    logic       rx_int;
    logic       frame_err;

    modport master (
        output rs232_rx,
        input  rx_data,
        input  rx_int,
        input  frame_err
    );

    modport slave (
        input  rs232_rx,
        output rx_data,
        output rx_int,
        output frame_err
    );
endinterface

// File: rtl/uart_rx_os.sv
// Self-timed 8N1 UART receiver.
// Mid-bit 3-sample majority vote, edge-triggered start detection.
module uart_rx_os #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_rx_os_if.slave  rx_if
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int MID      = BAUD_DIV / 2;
    localparam int CW       = $clog2(BAUD_DIV);

    localparam logic [CW-1:0] C_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] C_V0   = CW'(MID - 1);
    localparam logic [CW-1:0] C_V1   = CW'(MID);
    localparam logic [CW-1:0] C_VOTE = CW'(MID + 1);

    if (BAUD_DIV < 8) begin : g_div_chk
        $error("uart_rx_os: BAUD_DIV must be >= 8");
    end

    typedef enum logic {IDLE, RECV} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          v0_q, v0_d;
    logic          v1_q, v1_d;
    logic [7:0]    data_q, data_d;
    logic          int_q, int_d;
    logic          ferr_q, ferr_d;
    logic          s1_q, s2_q, s3_q;
    logic          fall;
    logic          vote;

    assign fall = s3_q & ~s2_q;
    assign vote = (v0_q & v1_q) | (v0_q & s2_q) | (v1_q & s2_q);

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_int    = int_q;
    assign rx_if.frame_err = ferr_q;

    // Two-flop synchronizer plus one flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= rx_if.rs232_rx;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Receiver state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            data_q  <= '0;
            int_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            data_q  <= data_d;
            int_q   <= int_d;
            ferr_q  <= ferr_d;
        end
    end

    // Bit timing, sample voting and frame assembly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        data_d  = data_q;
        int_d   = int_q;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                // The fall cycle itself counts as cnt = 0.
                if (fall) begin
                    state_d = RECV;
                    cnt_d   = CW'(1);
                end
            end
            RECV: begin
                if (cnt_q == C_LAST) begin
                    cnt_d = '0;
                    bit_d = bit_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (cnt_q == C_V0) v0_d = s2_q;
                if (cnt_q == C_V1) v1_d = s2_q;
                if (cnt_q == C_VOTE) begin
                    if (bit_q == 4'd0) begin
                        if (vote) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            bit_d   = '0;
                        end else begin
                            int_d = 1'b1;
                        end
                    end else if (bit_q == 4'd9) begin
                        // Leave half a bit early so a
                        // back-to-back start edge is caught.
                        data_d  = shift_q;
                        int_d   = 1'b0;
                        ferr_d  = ~vote;
                        state_d = IDLE;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end else begin
                        shift_d = {vote, shift_q[7:1]};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
